// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the sequenced IIR filter.
package iir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Width used for the round/shift/saturate datapath; wide enough for any
    // legal accumulator (NB up to ~28 with ORDER up to 8).
    localparam int SCALE_W = 64;

    // Accumulator width: full product width plus growth for 2*ORDER+1 terms.
    function automatic int acc_width(input int nb, input int order);
        return 2 * nb + $clog2(2 * order + 1);
    endfunction

    // Half an output LSB, added before the arithmetic right shift.
    function automatic logic signed [SCALE_W-1:0] round_const(input int frac);
        logic signed [SCALE_W-1:0] one;
        one = 64'sd1;
        if (frac > 0) begin
            return one <<< (frac - 1);
        end
        return '0;
    endfunction

    // Clamp a value into the signed range of an nb-bit word.
    function automatic logic signed [SCALE_W-1:0] sat(input logic signed [SCALE_W-1:0] value,
                                                      input int nb);
        logic signed [SCALE_W-1:0] one;
        logic signed [SCALE_W-1:0] hi;
        logic signed [SCALE_W-1:0] lo;
        one = 64'sd1;
        hi  = (one <<< (nb - 1)) - one;
        lo  = -(one <<< (nb - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/iir_mac_seq_if.sv
// Sample/coefficient bus between the data source, the filter and the sink.
interface iir_mac_seq_if #(
    parameter int NB    = 10,
    parameter int ORDER = 2
);
    localparam int CAW = $clog2(2 * ORDER + 1);

    logic                 clr;
    logic signed [NB-1:0] x;
    logic                 vin;
    logic                 ready;
    logic                 cwe;
    logic [CAW-1:0]       caddr;
    logic signed [NB-1:0] cdata;
    logic signed [NB-1:0] y;
    logic                 vout;

    modport master (
        output clr, x, vin, cwe, caddr, cdata,
        input  ready, y, vout
    );

    modport slave (
        input  clr, x, vin, cwe, caddr, cdata,
        output ready, y, vout
    );
endinterface

// File: rtl/iir_mac.sv
// Single signed multiply-accumulate unit; one product per enabled cycle.
module iir_mac
    import iir_pkg::*;
#(
    parameter  int NB    = 10,
    parameter  int ORDER = 2,
    localparam int AW    = acc_width(NB, ORDER)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic                 i_sub,
    input  logic signed [NB-1:0] i_a,
    input  logic signed [NB-1:0] i_b,
    output logic signed [AW-1:0] o_acc
);

    logic signed [2*NB-1:0] w_prod;
    logic signed [AW-1:0]   w_term;
    logic signed [AW-1:0]   r_acc;

    assign w_prod = (2*NB)'(i_a) * (2*NB)'(i_b);
    assign w_term = AW'(w_prod);
    assign o_acc  = r_acc;

    // Clear wins over accumulate; feedback taps are subtracted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            if (i_sub) begin
                r_acc <= r_acc - w_term;
            end else begin
                r_acc <= r_acc + w_term;
            end
        end
    end

endmodule

// File: rtl/iir_mac_seq.sv
// Time-multiplexed direct-form-I IIR filter: one MAC walks all taps per sample.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready; accepts a sample (VIN) or a coefficient write (CWE)
//   ST_MAC  | one tap per cycle: b0..bORDER on x history, a1..aORDER on y
//   ST_OUT  | round/saturate accumulator into Y, pulse VOUT, shift y history
module iir_mac_seq
    import iir_pkg::*;
#(
    parameter int NB    = 10,
    parameter int ORDER = 2,
    parameter int FRAC  = NB - 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    iir_mac_seq_if.slave  io_bus
);

    localparam int             NTAP     = 2 * ORDER + 1;
    localparam int             CAW      = $clog2(NTAP);
    localparam int             AW       = acc_width(NB, ORDER);
    localparam logic [CAW-1:0] LAST_TAP = CAW'(NTAP - 1);

    state_t               r_state;
    logic [CAW-1:0]       r_tap;
    logic signed [NB-1:0] r_coef [NTAP];
    logic signed [NB-1:0] r_xh   [ORDER+1];
    logic signed [NB-1:0] r_yh   [ORDER];
    logic signed [NB-1:0] r_y;
    logic                 r_vout;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_cwr;
    logic                 w_mac_clr;
    logic                 w_mac_en;
    logic                 w_sub;
    logic signed [NB-1:0] w_opa;
    logic signed [NB-1:0] w_opb;
    logic signed [AW-1:0] w_acc;
    logic signed [63:0]   w_acc_ext;
    logic signed [63:0]   w_scaled;
    logic signed [NB-1:0] w_ynext;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_accept  = w_idle && io_bus.vin && !io_bus.clr;
    assign w_cwr     = w_idle && io_bus.cwe && !io_bus.clr && (io_bus.caddr <= LAST_TAP);
    assign w_mac_clr = io_bus.clr || w_accept;
    assign w_mac_en  = (r_state == ST_MAC);

    assign io_bus.ready = w_idle;
    assign io_bus.y     = r_y;
    assign io_bus.vout  = r_vout;

    // Accumulator holds still in ST_OUT, so the scaled result is stable there.
    assign w_acc_ext = {{(64-AW){w_acc[AW-1]}}, w_acc};
    assign w_scaled  = (w_acc_ext + round_const(FRAC)) >>> FRAC;
    assign w_ynext   = NB'(sat(w_scaled, NB));

    iir_mac #(
        .NB    (NB),
        .ORDER (ORDER)
    ) u_mac (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_sub (w_sub),
        .i_a   (w_opa),
        .i_b   (w_opb),
        .o_acc (w_acc)
    );

    // Operand select: feed-forward taps first, then feedback taps.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        w_sub = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin
            if (r_tap == CAW'(k)) begin
                w_opa = r_coef[k];
                w_opb = r_xh[k];
            end
        end
        for (int k = 0; k < ORDER; k++) begin
            if (r_tap == CAW'(ORDER + 1 + k)) begin
                w_opa = r_coef[ORDER + 1 + k];
                w_opb = r_yh[k];
                w_sub = 1'b1;
            end
        end
    end

    // Coefficient register file; only writable while idle, survives CLR.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NTAP; k++) begin
                r_coef[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NTAP; k++) begin
                if (w_cwr && (io_bus.caddr == CAW'(k))) begin
                    r_coef[k] <= io_bus.cdata;
                end
            end
        end
    end

    // Sequencer with histories, output register and VOUT strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_tap   <= '0;
            r_y     <= '0;
            r_vout  <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                r_xh[k] <= '0;
            end
            for (int k = 0; k < ORDER; k++) begin
                r_yh[k] <= '0;
            end
        end else if (io_bus.clr) begin
            r_state <= ST_IDLE;
            r_tap   <= '0;
            r_vout  <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                r_xh[k] <= '0;
            end
            for (int k = 0; k < ORDER; k++) begin
                r_yh[k] <= '0;
            end
        end else begin
            r_vout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.vin) begin
                        for (int k = ORDER; k > 0; k--) begin
                            r_xh[k] <= r_xh[k-1];
                        end
                        r_xh[0] <= io_bus.x;
                        r_tap   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_tap <= r_tap + CAW'(1);
                    if (r_tap == LAST_TAP) begin
                        r_state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    r_y    <= w_ynext;
                    r_vout <= 1'b1;
                    for (int k = ORDER - 1; k > 0; k--) begin
                        r_yh[k] <= r_yh[k-1];
                    end
                    r_yh[0] <= w_ynext;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_mac_seq.sv
// Bench for iir_mac_seq: one ORDER=1 and one ORDER=2 instance, checked
// against a plain-arithmetic difference-equation model.
module tb_iir_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int m_coef [1:2][0:16];
    int m_x    [1:2][0:8];
    int m_y    [1:2][0:7];
    int imp_seq [0:5];

    iir_mac_seq_if #(.NB(10), .ORDER(1)) if1 ();
    iir_mac_seq_if #(.NB(10), .ORDER(2)) if2 ();

    iir_mac_seq #(.NB(10), .ORDER(1), .FRAC(9)) u_dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (if1)
    );

    iir_mac_seq #(.NB(10), .ORDER(2), .FRAC(9)) u_dut2 (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (if2)
    );

    function automatic int ordr(input int s);
        return (s == 1) ? 1 : 2;
    endfunction

    // ---------------- reference model ----------------
    task automatic m_reset(input int s);
        for (int k = 0; k <= 16; k++) m_coef[s][k] = 0;
        for (int k = 0; k <= 8; k++) m_x[s][k] = 0;
        for (int k = 0; k <= 7; k++) m_y[s][k] = 0;
    endtask

    task automatic m_clear(input int s);
        for (int k = 0; k <= 8; k++) m_x[s][k] = 0;
        for (int k = 0; k <= 7; k++) m_y[s][k] = 0;
    endtask

    task automatic m_write(input int s, input int a, input int d);
        if (a >= 0 && a <= 2 * ordr(s)) m_coef[s][a] = d;
    endtask

    task automatic m_sample(input int s, input int xv, output int yv);
        int o;
        int acc;
        o = ordr(s);
        for (int k = o; k > 0; k--) m_x[s][k] = m_x[s][k-1];
        m_x[s][0] = xv;
        acc = 0;
        for (int k = 0; k <= o; k++) acc += m_coef[s][k] * m_x[s][k];
        for (int k = 1; k <= o; k++) acc -= m_coef[s][o + k] * m_y[s][k-1];
        yv = (acc + 256) >>> 9;
        if (yv > 511) yv = 511;
        if (yv < -512) yv = -512;
        for (int k = o - 1; k > 0; k--) m_y[s][k] = m_y[s][k-1];
        m_y[s][0] = yv;
    endtask

    // ---------------- DUT access ----------------
    task automatic set_in(input int s, input bit v, input int xv, input bit w,
                          input int a, input int d, input bit c);
        if (s == 1) begin
            if1.vin = v; if1.x = 10'(xv); if1.cwe = w;
            if1.caddr = 2'(a); if1.cdata = 10'(d); if1.clr = c;
        end else begin
            if2.vin = v; if2.x = 10'(xv); if2.cwe = w;
            if2.caddr = 3'(a); if2.cdata = 10'(d); if2.clr = c;
        end
    endtask

    task automatic get_out(input int s, output bit rdy, output int yv, output bit vo);
        if (s == 1) begin
            rdy = if1.ready; yv = int'(if1.y); vo = if1.vout;
        end else begin
            rdy = if2.ready; yv = int'(if2.y); vo = if2.vout;
        end
    endtask

    task automatic write_coef(input int s, input int a, input int d);
        @(negedge clk);
        set_in(s, 1'b0, 0, 1'b1, a, d, 1'b0);
        @(posedge clk); #1;
        set_in(s, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        m_write(s, a, d);
    endtask

    task automatic do_clr(input int s);
        @(negedge clk);
        set_in(s, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        @(posedge clk); #1;
        set_in(s, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        m_clear(s);
    endtask

    // Offer one sample (optionally with a same-edge coefficient write) and
    // wait, bounded, for VOUT. lat counts edges after the accepting edge.
    task automatic send(input int s, input int xv, input bit w, input int a, input int d,
                        output int yv, output int lat, output bit rdy0);
        bit rdy;
        bit vo;
        int yy;
        int n;
        @(negedge clk);
        get_out(s, rdy0, yy, vo);
        set_in(s, 1'b1, xv, w, a, d, 1'b0);
        @(posedge clk); #1;
        set_in(s, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        lat = -1;
        yv  = 0;
        n   = 0;
        while (lat < 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
            get_out(s, rdy, yy, vo);
            if (vo) begin
                lat = n;
                yv  = yy;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit rdy, vo, r0, seen;
        int yv, ey, lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset(1);
        m_reset(2);
        for (int s = 1; s <= 2; s++) begin
            get_out(s, rdy, yv, vo);
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%0b want=1", s, rdy); end
            total++; if (vo !== 1'b0) begin bad++; $display("FAIL reset_vout[%0d] got=%0b want=0", s, vo); end
            total++; if (yv !== 0) begin bad++; $display("FAIL reset_y[%0d] got=%0d want=0", s, yv); end
        end
        write_coef(2, 0, 256);
        m_sample(2, 256, ey);
        send(2, 256, 1'b0, 0, 0, yv, lat, r0);
        total++; if (yv !== ey) begin bad++; $display("FAIL pre_reset_y got=%0d want=%0d", yv, ey); end
        // abort a sample in flight with an asynchronous reset
        @(negedge clk);
        set_in(2, 1'b1, 256, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        set_in(2, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        get_out(2, rdy, yv, vo);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b want=1", rdy); end
        total++; if (vo !== 1'b0) begin bad++; $display("FAIL midrst_vout got=%0b want=0", vo); end
        total++; if (yv !== 0) begin bad++; $display("FAIL midrst_y got=%0d want=0", yv); end
        @(negedge clk);
        rst = 1'b0;
        m_reset(1);
        m_reset(2);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            get_out(2, rdy, yv, vo);
            if (vo) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_vout got=%0b want=0", seen); end
        m_sample(2, 300, ey);
        send(2, 300, 1'b0, 0, 0, yv, lat, r0);
        total++; if (yv !== ey) begin bad++; $display("FAIL zero_coef_y got=%0d want=%0d", yv, ey); end
        total++; if (lat !== 6) begin bad++; $display("FAIL zero_coef_lat got=%0d want=6", lat); end
    endtask

    task automatic test_impulse();
        int yv, ey, lat, xv;
        bit r0;
        write_coef(1, 0, 256);
        write_coef(1, 1, 0);
        write_coef(1, 2, -256);
        for (int i = 0; i < 6; i++) begin
            xv = (i == 0) ? 256 : 0;
            m_sample(1, xv, ey);
            send(1, xv, 1'b0, 0, 0, yv, lat, r0);
            imp_seq[i] = yv;
            total++; if (yv !== ey) begin bad++; $display("FAIL impulse_y[%0d] got=%0d want=%0d", i, yv, ey); end
            total++; if (yv !== (128 >>> i)) begin bad++; $display("FAIL impulse_seq[%0d] got=%0d want=%0d", i, yv, 128 >>> i); end
            total++; if (lat !== 4) begin bad++; $display("FAIL impulse_lat[%0d] got=%0d want=4", i, lat); end
            total++; if (r0 !== 1'b1) begin bad++; $display("FAIL impulse_ready[%0d] got=%0b want=1", i, r0); end
        end
    endtask

    task automatic test_saturation();
        int xs [4];
        int ys [4];
        int yv, ey, lat;
        bit r0;
        xs = '{511, 511, -512, -512};
        ys = '{510, 511, -1, -512};
        do_clr(1);
        write_coef(1, 0, 511);
        write_coef(1, 1, 511);
        write_coef(1, 2, 0);
        for (int i = 0; i < 4; i++) begin
            m_sample(1, xs[i], ey);
            send(1, xs[i], 1'b0, 0, 0, yv, lat, r0);
            total++; if (yv !== ey) begin bad++; $display("FAIL sat_model[%0d] got=%0d want=%0d", i, yv, ey); end
            total++; if (yv !== ys[i]) begin bad++; $display("FAIL sat_value[%0d] got=%0d want=%0d", i, yv, ys[i]); end
        end
    endtask

    task automatic test_rounding();
        int xs [3];
        int ys [3];
        int yv, ey, lat;
        bit r0;
        xs = '{256, 255, -256};
        ys = '{1, 0, 0};
        do_clr(1);
        write_coef(1, 0, 1);
        write_coef(1, 1, 0);
        write_coef(1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            m_sample(1, xs[i], ey);
            send(1, xs[i], 1'b0, 0, 0, yv, lat, r0);
            total++; if (yv !== ys[i]) begin bad++; $display("FAIL round[%0d] got=%0d want=%0d", i, yv, ys[i]); end
            total++; if (yv !== ey) begin bad++; $display("FAIL round_model[%0d] got=%0d want=%0d", i, yv, ey); end
        end
        // write and sample on the same idle edge: new b0=4 must be used
        m_write(1, 0, 4);
        m_sample(1, 256, ey);
        send(1, 256, 1'b1, 0, 4, yv, lat, r0);
        total++; if (yv !== 2) begin bad++; $display("FAIL cwe_vin_same_edge got=%0d want=2", yv); end
        total++; if (yv !== ey) begin bad++; $display("FAIL cwe_vin_model got=%0d want=%0d", yv, ey); end
    endtask

    task automatic test_random();
        int yv, ey, lat, xv, a, d;
        bit r0;
        do_clr(2);
        for (int k = 0; k < 5; k++) write_coef(2, k, int'($urandom_range(400, 0)) - 200);
        write_coef(2, 5, int'($urandom_range(1023, 0)) - 512);
        write_coef(2, 7, int'($urandom_range(1023, 0)) - 512);
        for (int i = 0; i < 16; i++) begin
            xv = int'($urandom_range(1023, 0)) - 512;
            if (i == 8) begin
                a = int'($urandom_range(4, 0));
                d = int'($urandom_range(400, 0)) - 200;
                m_write(2, a, d);
                m_sample(2, xv, ey);
                send(2, xv, 1'b1, a, d, yv, lat, r0);
            end else begin
                m_sample(2, xv, ey);
                send(2, xv, 1'b0, 0, 0, yv, lat, r0);
            end
            total++; if (yv !== ey) begin bad++; $display("FAIL rand_y[%0d] got=%0d want=%0d", i, yv, ey); end
            total++; if (lat !== 6) begin bad++; $display("FAIL rand_lat[%0d] got=%0d want=6", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        int q [$];
        int yv, ey, xv;
        bit rdy, vo;
        write_coef(2, 0, 200);
        write_coef(2, 1, -100);
        write_coef(2, 2, 50);
        write_coef(2, 3, 100);
        write_coef(2, 4, -30);
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            get_out(2, rdy, yv, vo);
            total++; if (rdy !== (c % 7 == 0)) begin bad++; $display("FAIL b2b_ready[%0d] got=%0b want=%0b", c, rdy, (c % 7 == 0)); end
            xv = ((c * 37) % 1000) - 500;
            set_in(2, 1'b1, xv, (c == 3), 0, -300, 1'b0);
            if (c % 7 == 0) begin
                m_sample(2, xv, ey);
                q.push_back(ey);
            end
            @(posedge clk); #1;
            get_out(2, rdy, yv, vo);
            total++; if (vo !== (c % 7 == 6)) begin bad++; $display("FAIL b2b_vout[%0d] got=%0b want=%0b", c, vo, (c % 7 == 6)); end
            if (vo && q.size() > 0) begin
                ey = q.pop_front();
                total++; if (yv !== ey) begin bad++; $display("FAIL b2b_y[%0d] got=%0d want=%0d", c, yv, ey); end
            end
        end
        set_in(2, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        total++; if (q.size() !== 0) begin bad++; $display("FAIL b2b_pending got=%0d want=0", q.size()); end
    endtask

    task automatic test_clr();
        int yv, ey, lat, xv;
        bit rdy, vo, r0, seen;
        do_clr(1);
        write_coef(1, 0, 256);
        write_coef(1, 1, 0);
        write_coef(1, 2, -256);
        m_sample(1, 256, ey);
        send(1, 256, 1'b0, 0, 0, yv, lat, r0);
        total++; if (yv !== ey) begin bad++; $display("FAIL clr_pre_y got=%0d want=%0d", yv, ey); end
        @(negedge clk);
        set_in(1, 1'b1, 100, 1'b0, 0, 0, 1'b0);
        @(posedge clk); #1;
        set_in(1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        set_in(1, 1'b0, 0, 1'b0, 0, 0, 1'b1);
        @(posedge clk); #1;
        set_in(1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        m_clear(1);
        get_out(1, rdy, yv, vo);
        total++; if (rdy !== 1'b1) begin bad++; $display("FAIL clr_ready got=%0b want=1", rdy); end
        total++; if (yv !== 128) begin bad++; $display("FAIL clr_y_held got=%0d want=128", yv); end
        seen = vo;
        repeat (8) begin
            @(posedge clk); #1;
            get_out(1, rdy, yv, vo);
            if (vo) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL clr_no_vout got=%0b want=0", seen); end
        for (int i = 0; i < 6; i++) begin
            xv = (i == 0) ? 256 : 0;
            m_sample(1, xv, ey);
            send(1, xv, 1'b0, 0, 0, yv, lat, r0);
            total++; if (yv !== imp_seq[i]) begin bad++; $display("FAIL clr_impulse[%0d] got=%0d want=%0d", i, yv, imp_seq[i]); end
            total++; if (yv !== ey) begin bad++; $display("FAIL clr_model[%0d] got=%0d want=%0d", i, yv, ey); end
        end
    endtask

    initial begin
        set_in(1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        set_in(2, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_random();
        test_back_to_back();
        test_clr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
